// File: rtl/ssd_scan_ctrl_if.sv
// Bundle of the CPU-side request/status lines and the board display pins for ssd_scan_ctrl.
// Handshake: load is accepted on a rising edge only while busy=0; busy then stays high until the new digits are committed.
interface ssd_scan_ctrl_if #(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
);
    logic [DATA_W-1:0]     value;
    logic [1:0]            mode;
    logic                  load;
    logic                  busy;
    logic                  overflow;
    logic [NUM_DIGITS-1:0] anode;
    logic [6:0]            seg;
    logic                  dp;

    modport master (
        output value, mode, load,
        input  busy, overflow, anode, seg, dp
    );

    modport slave (
        input  value, mode, load,
        output busy, overflow, anode, seg, dp
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller: hex / unsigned / signed decimal display of a CPU value,
// with sequential double-dabble conversion and a free-running multiplexed digit scan.
module ssd_scan_ctrl #(
    parameter int DATA_W      = 16,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic           clk,
    input  logic           rst,
    ssd_scan_ctrl_if.slave bus,
    output logic [1:0]     dbg_state
);
    localparam int BCD_DIGITS = (DATA_W * 3) / 10 + 1;
    localparam int BCD_W      = BCD_DIGITS * 4;
    localparam int PAD_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int PAD_W      = PAD_DIGITS * 4;
    localparam int HEX_W      = NUM_DIGITS * 4;
    localparam int CNT_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ITER_W     = $clog2(DATA_W + 1);

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   load_ok;
    logic   is_dec;

    logic [DATA_W-1:0] sh;
    logic [BCD_W-1:0]  bcd, bcd_adj;
    logic [ITER_W-1:0] iter;
    logic              dec_mode, signed_mode, neg;

    logic [6:0] disp     [NUM_DIGITS];
    logic [6:0] disp_nxt [NUM_DIGITS];
    logic       overflow_r, ovf_nxt;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [NUM_DIGITS-1:0] anode_r;
    logic [6:0]            seg_r;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'h0: seg_code = 7'b1000000;
            4'h1: seg_code = 7'b1111001;
            4'h2: seg_code = 7'b0100100;
            4'h3: seg_code = 7'b0110000;
            4'h4: seg_code = 7'b0011001;
            4'h5: seg_code = 7'b0010010;
            4'h6: seg_code = 7'b0000010;
            4'h7: seg_code = 7'b1111000;
            4'h8: seg_code = 7'b0000000;
            4'h9: seg_code = 7'b0010000;
            4'hA: seg_code = 7'b0001000;
            4'hB: seg_code = 7'b0000011;
            4'hC: seg_code = 7'b1000110;
            4'hD: seg_code = 7'b0100001;
            4'hE: seg_code = 7'b0000110;
            default: seg_code = 7'b0001110;
        endcase
    endfunction

    assign is_dec = (bus.mode == 2'b01) || (bus.mode == 2'b10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_ok   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.load) begin
                    load_ok   = 1'b1;
                    state_nxt = is_dec ? S_CONV : S_COMMIT;
                end
            end
            S_CONV: begin
                if (iter == ITER_W'(DATA_W - 1)) state_nxt = S_COMMIT;
            end
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Add-3 correction applied to every BCD digit before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int j = 0; j < BCD_DIGITS; j++) begin
            if (bcd[j*4 +: 4] >= 4'd5) bcd_adj[j*4 +: 4] = bcd[j*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh          <= '0;
            bcd         <= '0;
            iter        <= '0;
            dec_mode    <= 1'b0;
            signed_mode <= 1'b0;
            neg         <= 1'b0;
            overflow_r  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= SEG_ZERO;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_ok) begin
                        dec_mode    <= is_dec;
                        signed_mode <= (bus.mode == 2'b10);
                        bcd         <= '0;
                        iter        <= '0;
                        if (bus.mode == 2'b10 && bus.value[DATA_W-1]) begin
                            sh  <= ~bus.value + DATA_W'(1);
                            neg <= 1'b1;
                        end else begin
                            sh  <= bus.value;
                            neg <= 1'b0;
                        end
                    end
                end
                S_CONV: begin
                    {bcd, sh} <= {bcd_adj, sh} << 1;
                    iter      <= iter + 1'b1;
                end
                S_COMMIT: begin
                    disp       <= disp_nxt;
                    overflow_r <= ovf_nxt;
                end
                default: ;
            endcase
        end
    end

    // Digit images for the commit: hex nibbles, or blanked/dashed decimal digits.
    logic [HEX_W-1:0] hex_pad;
    logic [PAD_W-1:0] bcd_pad;
    logic             nz;
    int               limit;

    always_comb begin
        hex_pad = HEX_W'(sh);
        bcd_pad = PAD_W'(bcd);
        ovf_nxt = 1'b0;
        nz      = 1'b0;
        limit   = signed_mode ? NUM_DIGITS - 1 : NUM_DIGITS;
        for (int i = 0; i < NUM_DIGITS; i++) disp_nxt[i] = SEG_BLANK;
        if (!dec_mode) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i < DATA_W / 4) disp_nxt[i] = seg_code(hex_pad[i*4 +: 4]);
            end
        end else begin
            for (int j = 0; j < PAD_DIGITS; j++) begin
                if (j >= limit && bcd_pad[j*4 +: 4] != 4'd0) ovf_nxt = 1'b1;
            end
            if (ovf_nxt) begin
                for (int i = 0; i < NUM_DIGITS; i++) disp_nxt[i] = SEG_DASH;
            end else begin
                for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                    if (bcd_pad[i*4 +: 4] != 4'd0) nz = 1'b1;
                    if (nz || i == 0) disp_nxt[i] = seg_code(bcd_pad[i*4 +: 4]);
                end
                if (neg) disp_nxt[NUM_DIGITS-1] = SEG_DASH;
            end
        end
    end

    assign idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

    // seg reloads the current digit between advances so a commit shows up one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            anode_r <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
            seg_r   <= SEG_ZERO;
        end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt     <= '0;
            idx     <= idx_nxt;
            anode_r <= ~(NUM_DIGITS'(1) << idx_nxt);
            seg_r   <= disp[idx_nxt];
        end else begin
            cnt   <= cnt + 1'b1;
            seg_r <= disp[idx];
        end
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.overflow = overflow_r;
    assign bus.anode    = anode_r;
    assign bus.seg      = seg_r;
    assign bus.dp       = 1'b1;
    assign dbg_state    = state;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: directed loads queue their expected display; a monitor pops one
// entry each time busy falls and checks busy length, overflow and the scanned digit codes.
module tb_ssd_scan_ctrl;
  localparam int DATA_W      = 16;
  localparam int NUM_DIGITS  = 4;
  localparam int REFRESH_DIV = 4;
  localparam int W           = 34;  // {busy_len[4:0], overflow, d3, d2, d1, d0}

  localparam logic [6:0] S_0 = 7'b1000000, S_1 = 7'b1111001, S_2 = 7'b0100100;
  localparam logic [6:0] S_3 = 7'b0110000, S_4 = 7'b0011001, S_5 = 7'b0010010;
  localparam logic [6:0] S_6 = 7'b0000010, S_7 = 7'b1111000, S_B = 7'b0000011;
  localparam logic [6:0] S_E = 7'b0000110, S_F = 7'b0001110;
  localparam logic [6:0] DA  = 7'b0111111, BL  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  ssd_scan_ctrl_if #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) bus ();

  ssd_scan_ctrl #(
    .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Watch one full scan frame and collect the seg code shown under each anode.
  task automatic capture_frame(output logic [27:0] segs, output bit ok);
    logic [3:0] seen;
    seen = 4'h0;
    segs = '0;
    @(negedge clk);
    for (int n = 0; n < NUM_DIGITS * REFRESH_DIV * 3 && seen != 4'hF; n++) begin
      @(negedge clk);
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (bus.anode == ~(4'b0001 << d)) begin
          segs[d*7 +: 7] = bus.seg;
          seen[d] = 1'b1;
        end
      end
    end
    ok = (seen == 4'hF);
  endtask

  // driver
  task automatic run(input logic [15:0] v, input logic [1:0] m, input int len,
                     input logic ovf, input logic [27:0] segs, input bit mid_load);
    int start;
    int t;
    start = done_cnt;
    t = 0;
    exp_q.push_back({5'(len), ovf, segs});
    @(posedge clk); #1;
    bus.value = v;
    bus.mode  = m;
    bus.load  = 1'b1;
    @(posedge clk); #1;
    bus.load  = 1'b0;
    bus.value = 16'($urandom);
    bus.mode  = 2'($urandom_range(0, 3));
    if (mid_load) begin
      repeat (4) @(posedge clk);
      #1;
      bus.value = 16'd1234;
      bus.mode  = 2'b01;
      bus.load  = 1'b1;
      @(posedge clk); #1;
      bus.load  = 1'b0;
    end
    while (done_cnt == start && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got no result for value %0h expected one within 400 cycles", v);
    end
  endtask

  // scoreboard monitor
  initial begin : monitor
    int busy_len;
    logic [W-1:0] e;
    logic [27:0] segs;
    bit ok;
    logic ovf;
    busy_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_len = 0;
      end else if (bus.busy) begin
        busy_len++;
      end else if (busy_len > 0) begin
        ovf = bus.overflow;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got busy pulse of %0d cycles expected none", busy_len);
        end else begin
          e = exp_q.pop_front();
          check("busy_len", 64'(busy_len), 64'(e[33:29]));
          check("overflow", 64'(ovf), 64'(e[28]));
          capture_frame(segs, ok);
          check("frame_complete", 64'(ok), 64'd1);
          check("digits", 64'(segs), 64'(e[27:0]));
        end
        busy_len = 0;
        done_cnt++;
      end
    end
  end

  initial begin : stimulus
    logic [27:0] segs;
    bit ok;
    logic [3:0] exp_an;
    bus.value = '0;
    bus.mode  = 2'b00;
    bus.load  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_anode", 64'(bus.anode), 64'(4'b1110));
    check("rst_seg", 64'(bus.seg), 64'(S_0));
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_dp", 64'(bus.dp), 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);
    exp_an = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      repeat (REFRESH_DIV) @(negedge clk);
      exp_an = {exp_an[2:0], exp_an[3]};
      check("scan_step", 64'(bus.anode), 64'(exp_an));
    end

    run(16'hBEEF, 2'b00, 1,  1'b0, {S_B, S_E, S_E, S_F}, 1'b0);
    run(16'h1234, 2'b11, 1,  1'b0, {S_1, S_2, S_3, S_4}, 1'b0);
    run(16'd1234, 2'b01, 17, 1'b0, {S_1, S_2, S_3, S_4}, 1'b0);
    run(16'd42,   2'b01, 17, 1'b0, {BL, BL, S_4, S_2},   1'b0);
    run(16'hFFFF, 2'b01, 17, 1'b1, {DA, DA, DA, DA},     1'b0);
    run(16'd0,    2'b01, 17, 1'b0, {BL, BL, BL, S_0},    1'b0);
    run(16'hFF85, 2'b10, 17, 1'b0, {DA, S_1, S_2, S_3},  1'b0);
    run(16'hFC18, 2'b10, 17, 1'b1, {DA, DA, DA, DA},     1'b0);
    run(16'h0141, 2'b10, 17, 1'b0, {BL, S_3, S_2, S_1},  1'b0);
    run(16'd567,  2'b01, 17, 1'b0, {BL, S_5, S_6, S_7},  1'b1);
    run(16'h03E8, 2'b10, 17, 1'b1, {DA, DA, DA, DA},     1'b0);

    // reset in the middle of a conversion
    @(posedge clk); #1;
    bus.value = 16'd1234;
    bus.mode  = 2'b01;
    bus.load  = 1'b1;
    @(posedge clk); #1;
    bus.load  = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_overflow", 64'(bus.overflow), 64'd0);
    check("midrst_anode", 64'(bus.anode), 64'(4'b1110));
    check("midrst_seg", 64'(bus.seg), 64'(S_0));
    check("midrst_state", 64'(dbg_state), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    capture_frame(segs, ok);
    check("midrst_frame_complete", 64'(ok), 64'd1);
    check("midrst_digits", 64'(segs), 64'({S_0, S_0, S_0, S_0}));
    check("midrst_no_result", 64'(done_cnt), 64'd11);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expected: got %0d unconsumed entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
